pipeline_ctrl: RTL and testbench

//  Hazard/flow controller for the 5-stage RV pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_if.sv | 36 +++
 rtl/pipeline_ctrl.sv | 78 +++++++
 tb/tb_pipeline_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flow controller.
// Control codes applied to the PC and every pipeline register, plus bus widths.
// No logic; imported by the interface and the controller.
package pipeline_ctrl_pkg;

    localparam int CTRL_W     = 2;
    localparam int ADDR_W_DEF = 32;

    // NORMAL advances, STALL holds, FLUSH loads a bubble, JUMP loads the redirect
    // target into the PC (never used on a stage register).
    typedef enum logic [CTRL_W-1:0] {
        CTRL_NORMAL = 2'b00,
        CTRL_STALL  = 2'b01,
        CTRL_FLUSH  = 2'b10,
        CTRL_JUMP   = 2'b11
    } ctrl_code_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the 5-stage pipeline datapath and its hazard controller.
// master: datapath side (drives hazard inputs, consumes control codes).
// slave : controller side (consumes hazard inputs, drives codes and redirect target).
interface pipeline_ctrl_if #(
    parameter int ADDR_W = pipeline_ctrl_pkg::ADDR_W_DEF
) ();
    import pipeline_ctrl_pkg::*;

    logic              dcache_ready_i;
    logic              icache_data_valid_i;
    logic              ex_branch_flag_i;
    logic [ADDR_W-1:0] ex_pc_new_i;
    logic              mem_block_flag_i;

    ctrl_code_t        ctrl_signal_pc_o;
    ctrl_code_t        ctrl_signal_if_id_o;
    ctrl_code_t        ctrl_signal_id_ex_o;
    ctrl_code_t        ctrl_signal_ex_mem_o;
    ctrl_code_t        ctrl_signal_mem_wb_o;
    logic [ADDR_W-1:0] ctrl_to_pc_new_o;

    modport master (
        output dcache_ready_i, icache_data_valid_i, ex_branch_flag_i,
               ex_pc_new_i, mem_block_flag_i,
        input  ctrl_signal_pc_o, ctrl_signal_if_id_o, ctrl_signal_id_ex_o,
               ctrl_signal_ex_mem_o, ctrl_signal_mem_wb_o, ctrl_to_pc_new_o
    );

    modport slave (
        input  dcache_ready_i, icache_data_valid_i, ex_branch_flag_i,
               ex_pc_new_i, mem_block_flag_i,
        output ctrl_signal_pc_o, ctrl_signal_if_id_o, ctrl_signal_id_ex_o,
               ctrl_signal_ex_mem_o, ctrl_signal_mem_wb_o, ctrl_to_pc_new_o
    );

endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/flow controller: per-stage control codes and PC redirect for a 5-stage pipeline.
// Latency: zero cycles inputs->codes; a redirect lands in the PC at the next clock edge.
// Backpressure: dcache/memory stall freezes PC..EX_MEM and bubbles MEM_WB; fetch miss holds PC.
// Ports: clk, rst (synchronous, active-low), bus (pipeline_ctrl_if.slave: hazard inputs in,
//        five control codes and the PC load value out).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input logic             clk,
    input logic             rst,
    pipeline_ctrl_if.slave  bus
);

    // BOOT gives the pipeline one bubble-filled cycle after reset release.
    // SQUASH means the fetch currently in flight is from the wrong path.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_BOOT   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   memstall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    assign memstall = bus.mem_block_flag_i | ~bus.dcache_ready_i;

    always_comb begin
        state_nxt                = state;
        bus.ctrl_signal_pc_o     = CTRL_NORMAL;
        bus.ctrl_signal_if_id_o  = CTRL_NORMAL;
        bus.ctrl_signal_id_ex_o  = CTRL_NORMAL;
        bus.ctrl_signal_ex_mem_o = CTRL_NORMAL;
        bus.ctrl_signal_mem_wb_o = CTRL_NORMAL;
        bus.ctrl_to_pc_new_o     = '0;

        if (!rst || state == ST_BOOT) begin
            // Reset and the boot cycle: fill every stage with bubbles, hold PC.
            bus.ctrl_signal_pc_o     = CTRL_STALL;
            bus.ctrl_signal_if_id_o  = CTRL_FLUSH;
            bus.ctrl_signal_id_ex_o  = CTRL_FLUSH;
            bus.ctrl_signal_ex_mem_o = CTRL_FLUSH;
            bus.ctrl_signal_mem_wb_o = CTRL_FLUSH;
            state_nxt                = ST_RUN;
        end else if (memstall) begin
            // EX is frozen, so a pending branch flag simply re-presents next cycle.
            bus.ctrl_signal_pc_o     = CTRL_STALL;
            bus.ctrl_signal_if_id_o  = CTRL_STALL;
            bus.ctrl_signal_id_ex_o  = CTRL_STALL;
            bus.ctrl_signal_ex_mem_o = CTRL_STALL;
            bus.ctrl_signal_mem_wb_o = CTRL_FLUSH;
        end else if (bus.ex_branch_flag_i) begin
            // Redirect; the fetch issued this cycle is wrong-path and gets squashed later.
            bus.ctrl_signal_pc_o     = CTRL_JUMP;
            bus.ctrl_to_pc_new_o     = bus.ex_pc_new_i;
            bus.ctrl_signal_if_id_o  = CTRL_FLUSH;
            bus.ctrl_signal_id_ex_o  = CTRL_FLUSH;
            state_nxt                = ST_SQUASH;
        end else if (state == ST_SQUASH) begin
            // Drop the wrong-path fetch; stay here until the icache actually returns it.
            bus.ctrl_signal_if_id_o  = CTRL_FLUSH;
            bus.ctrl_signal_pc_o     = bus.icache_data_valid_i ? CTRL_NORMAL : CTRL_STALL;
            state_nxt                = bus.icache_data_valid_i ? ST_RUN : ST_SQUASH;
        end else if (!bus.icache_data_valid_i) begin
            bus.ctrl_signal_pc_o     = CTRL_STALL;
            bus.ctrl_signal_if_id_o  = CTRL_FLUSH;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the hazard priority rules.
module tb_pipeline_ctrl;

    localparam logic [1:0] C_N = 2'b00;
    localparam logic [1:0] C_S = 2'b01;
    localparam logic [1:0] C_F = 2'b10;
    localparam logic [1:0] C_J = 2'b11;

    typedef struct packed {
        logic [1:0]  pc;
        logic [1:0]  if_id;
        logic [1:0]  id_ex;
        logic [1:0]  ex_mem;
        logic [1:0]  mem_wb;
        logic [31:0] pc_new;
    } outv_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state: "just came out of reset" and "wrong-path fetch outstanding".
    bit m_after_reset = 1'b1;
    bit m_wrong_path  = 1'b0;

    outv_t obs;
    outv_t exp;

    pipeline_ctrl_if #(.ADDR_W(32)) bus ();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic outv_t model_expect();
        outv_t e;
        e = '{pc: C_N, if_id: C_N, id_ex: C_N, ex_mem: C_N, mem_wb: C_N, pc_new: 32'h0};
        if (!rst || m_after_reset) begin
            e = '{pc: C_S, if_id: C_F, id_ex: C_F, ex_mem: C_F, mem_wb: C_F, pc_new: 32'h0};
        end else if (bus.mem_block_flag_i || !bus.dcache_ready_i) begin
            e.pc = C_S; e.if_id = C_S; e.id_ex = C_S; e.ex_mem = C_S; e.mem_wb = C_F;
        end else if (bus.ex_branch_flag_i) begin
            e.pc = C_J; e.pc_new = bus.ex_pc_new_i; e.if_id = C_F; e.id_ex = C_F;
        end else if (m_wrong_path) begin
            e.if_id = C_F;
            e.pc    = bus.icache_data_valid_i ? C_N : C_S;
        end else if (!bus.icache_data_valid_i) begin
            e.pc = C_S; e.if_id = C_F;
        end
        return e;
    endfunction

    // Advance the model across the coming clock edge using the current inputs.
    function automatic void model_advance();
        if (!rst) begin
            m_after_reset = 1'b1;
            m_wrong_path  = 1'b0;
        end else if (m_after_reset) begin
            m_after_reset = 1'b0;
        end else if (bus.mem_block_flag_i || !bus.dcache_ready_i) begin
            m_wrong_path = m_wrong_path;
        end else if (bus.ex_branch_flag_i) begin
            m_wrong_path = 1'b1;
        end else if (m_wrong_path && bus.icache_data_valid_i) begin
            m_wrong_path = 1'b0;
        end
    endfunction

    function automatic outv_t sample();
        outv_t o;
        o.pc     = bus.ctrl_signal_pc_o;
        o.if_id  = bus.ctrl_signal_if_id_o;
        o.id_ex  = bus.ctrl_signal_id_ex_o;
        o.ex_mem = bus.ctrl_signal_ex_mem_o;
        o.mem_wb = bus.ctrl_signal_mem_wb_o;
        o.pc_new = bus.ctrl_to_pc_new_o;
        return o;
    endfunction

    // Apply inputs in the low clock phase and settle before sampling.
    task automatic drive(input logic r, input logic dr, input logic iv,
                         input logic br, input logic [31:0] pcn, input logic mb);
        @(negedge clk);
        rst                     = r;
        bus.dcache_ready_i      = dr;
        bus.icache_data_valid_i = iv;
        bus.ex_branch_flag_i    = br;
        bus.ex_pc_new_i         = pcn;
        bus.mem_block_flag_i    = mb;
        #1;
        obs = sample();
        exp = model_expect();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (obs !== {C_S, C_F, C_F, C_F, C_F, 32'h0}) begin
                errors++; $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, {C_S, C_F, C_F, C_F, C_F, 32'h0});
            end
            model_advance();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_S, C_F, C_F, C_F, C_F, 32'h0}) begin
            errors++; $display("FAIL reset_boot: got %h want %h", obs, {C_S, C_F, C_F, C_F, C_F, 32'h0});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_N, C_N, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL reset_run: got %h want %h", obs, {C_N, C_N, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0040, 1'b0);
        checks++;
        if (obs !== {C_J, C_F, C_F, C_N, C_N, 32'h8000_0040}) begin
            errors++; $display("FAIL branch_jump: got %h want %h", obs, {C_J, C_F, C_F, C_N, C_N, 32'h8000_0040});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        checks++;
        if (obs !== {C_N, C_F, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL branch_squash: got %h want %h", obs, {C_N, C_F, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_N, C_N, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL branch_resume: got %h want %h", obs, {C_N, C_N, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
    endtask

    task automatic test_memstall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if (obs !== {C_S, C_S, C_S, C_S, C_F, 32'h0}) begin
                errors++; $display("FAIL memstall[%0d]: got %h want %h", i, obs, {C_S, C_S, C_S, C_S, C_F, 32'h0});
            end
            model_advance();
        end
    endtask

    task automatic test_stall_branch();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0);
        checks++;
        if (obs !== {C_S, C_S, C_S, C_S, C_F, 32'h0}) begin
            errors++; $display("FAIL stall_branch_held: got %h want %h", obs, {C_S, C_S, C_S, C_S, C_F, 32'h0});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0);
        checks++;
        if (obs !== {C_J, C_F, C_F, C_N, C_N, 32'h0000_1000}) begin
            errors++; $display("FAIL stall_branch_taken: got %h want %h", obs, {C_J, C_F, C_F, C_N, C_N, 32'h0000_1000});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL stall_branch_squash: got %h want %h", obs, exp);
        end
        model_advance();
    endtask

    task automatic test_fetch_miss();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_S, C_F, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL fetch_miss: got %h want %h", obs, {C_S, C_F, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
    endtask

    task automatic test_squash_hold();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        model_advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            checks++;
            if (obs !== {C_S, C_F, C_N, C_N, C_N, 32'h0}) begin
                errors++; $display("FAIL squash_hold[%0d]: got %h want %h", i, obs, {C_S, C_F, C_N, C_N, C_N, 32'h0});
            end
            model_advance();
        end
        // Still squashing: the returning fetch is dropped while PC advances.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_N, C_F, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL squash_release: got %h want %h", obs, {C_N, C_F, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_N, C_N, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL squash_done: got %h want %h", obs, {C_N, C_N, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
        model_advance();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
        checks++;
        if (obs !== {C_J, C_F, C_F, C_N, C_N, 32'h0000_0400}) begin
            errors++; $display("FAIL b2b_second_jump: got %h want %h", obs, {C_J, C_F, C_F, C_N, C_N, 32'h0000_0400});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_S, C_F, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL b2b_fresh_squash: got %h want %h", obs, {C_S, C_F, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
    endtask

    task automatic test_reset_mid_squash();
        // Still in the squash left by the previous task.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_S, C_F, C_F, C_F, C_F, 32'h0}) begin
            errors++; $display("FAIL reset_mid_squash: got %h want %h", obs, {C_S, C_F, C_F, C_F, C_F, 32'h0});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_S, C_F, C_F, C_F, C_F, 32'h0}) begin
            errors++; $display("FAIL reset_mid_boot: got %h want %h", obs, {C_S, C_F, C_F, C_F, C_F, 32'h0});
        end
        model_advance();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs !== {C_S, C_F, C_N, C_N, C_N, 32'h0}) begin
            errors++; $display("FAIL reset_mid_clean: got %h want %h", obs, {C_S, C_F, C_N, C_N, C_N, 32'h0});
        end
        model_advance();
    endtask

    task automatic test_random();
        logic r, dr, iv, br, mb;
        logic [31:0] pcn;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 29) != 0);
            dr  = ($urandom_range(0, 4) != 0);
            iv  = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 3) == 0);
            mb  = ($urandom_range(0, 5) == 0);
            pcn = $urandom;
            drive(r, dr, iv, br, pcn, mb);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp);
            end
            model_advance();
        end
    endtask

    initial begin
        bus.dcache_ready_i      = 1'b1;
        bus.icache_data_valid_i = 1'b1;
        bus.ex_branch_flag_i    = 1'b0;
        bus.ex_pc_new_i         = 32'h0;
        bus.mem_block_flag_i    = 1'b0;
        test_reset();
        test_branch();
        test_memstall();
        test_stall_branch();
        test_fetch_miss();
        test_squash_hold();
        test_back_to_back();
        test_reset_mid_squash();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
